// File: rtl/mux_rr_sched.sv
// mux_rr_sched: round-robin owner of the 5:1 one-bit select mux.
// Grants one requester at a time for at most BURST_LEN cycles, drives the
// registered select/one-hot grant and registers the selected data bit.
// Optional build macro MUX_SCHED_B2B_EN: hand the mux straight to the next
// waiting requester on burst end instead of passing through GAP/IDLE.
module mux_rr_sched #(
    parameter int N_REQ     = 5,
    parameter int BURST_LEN = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req,
    input  logic [N_REQ-1:0] din,
    output logic [2:0]       sel,
    output logic [N_REQ-1:0] gnt,
    output logic             b,
    output logic             b_vld
);

    typedef enum logic [1:0] {IDLE, GRANT, GAP} state_t;

    state_t           state, state_nxt;
    logic [2:0]       ptr, ptr_nxt, sel_nxt, win;
    logic [3:0]       cnt, cnt_nxt;
    logic [N_REQ-1:0] gnt_nxt;
`ifdef MUX_SCHED_B2B_EN
    logic [N_REQ-1:0] req_other;
`endif

    // Owner index plus one, wrapping past the last requester.
    function automatic logic [2:0] wrap_inc(input logic [2:0] v);
        return (v == 3'(N_REQ - 1)) ? 3'd0 : v + 3'd1;
    endfunction

    // First set request at or after start, searching upward with wrap.
    // Scanning from the far end lets the nearest hit overwrite the result.
    function automatic logic [2:0] rr_pick(input logic [2:0] start,
                                           input logic [N_REQ-1:0] r);
        logic [2:0] w;
        logic [2:0] idx;
        w = start;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            idx = 3'((int'(start) + i) % N_REQ);
            if (r[idx]) w = idx;
        end
        return w;
    endfunction

    // Next-state and next-output decode for the arbitration FSM.
    always_comb begin
        state_nxt = state;
        sel_nxt   = sel;
        gnt_nxt   = gnt;
        ptr_nxt   = ptr;
        cnt_nxt   = cnt;
        win       = rr_pick(ptr, req);
`ifdef MUX_SCHED_B2B_EN
        req_other = req & ~(N_REQ'(1) << sel);
`endif
        case (state)
            IDLE: begin
                gnt_nxt = '0;
                if (|req) begin
                    sel_nxt   = win;
                    gnt_nxt   = N_REQ'(1) << win;
                    cnt_nxt   = 4'd0;
                    state_nxt = GRANT;
                end
            end
            GRANT: begin
                // Owner dropping its request takes priority over burst expiry;
                // both end the burst the same way.
                if (!req[sel] || cnt == 4'(BURST_LEN - 1)) begin
                    ptr_nxt   = wrap_inc(sel);
                    cnt_nxt   = 4'd0;
                    gnt_nxt   = '0;
                    state_nxt = GAP;
`ifdef MUX_SCHED_B2B_EN
                    if (|req_other) begin
                        win       = rr_pick(wrap_inc(sel), req_other);
                        sel_nxt   = win;
                        gnt_nxt   = N_REQ'(1) << win;
                        state_nxt = GRANT;
                    end
`endif
                end else begin
                    cnt_nxt = cnt + 4'd1;
                end
            end
            GAP: begin
                gnt_nxt   = '0;
                state_nxt = IDLE;
            end
            default: begin
                gnt_nxt   = '0;
                state_nxt = IDLE;
            end
        endcase
    end

    // Arbitration state, pointer, burst counter and registered select/grant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            sel   <= 3'd0;
            gnt   <= '0;
            ptr   <= 3'd0;
            cnt   <= 4'd0;
        end else begin
            state <= state_nxt;
            sel   <= sel_nxt;
            gnt   <= gnt_nxt;
            ptr   <= ptr_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Capture the granted lane's data bit; b keeps its last value once idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            b     <= 1'b0;
            b_vld <= 1'b0;
        end else begin
            b_vld <= |gnt;
            if (|gnt) b <= din[sel];
        end
    end

endmodule

// File: tb/tb_mux_rr_sched.sv
// Scoreboard bench for mux_rr_sched: an owner/burst-count model pushes
// cycle-tagged grant and data events; a negedge monitor pops and compares.
module tb_mux_rr_sched;
    localparam int N  = 5;
    localparam int BL = 4;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic [4:0] req   = '0;
    logic [4:0] din   = '0;
    logic [2:0] sel;
    logic [4:0] gnt;
    logic       b, b_vld;

    int vectors     = 0;
    int miscompares = 0;

    mux_rr_sched #(.N_REQ(N), .BURST_LEN(BL)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .din(din),
        .sel(sel), .gnt(gnt), .b(b), .b_vld(b_vld)
    );

    always #5 clk = ~clk;

    typedef struct { int cyc; int val; } ev_t;
    ev_t gq[$];
    ev_t dq[$];

    int cyc = 0, owner = -1, used = 0, dead = 0, ptr = 0, exp_sel = 0, nxt = -1;
    int last_b = 0;

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic timeout(input string name);
        vectors++;
        miscompares++;
        $display("FAIL %s: wait bound expired (t=%0t)", name, $time);
    endtask

    // Reference: who owns the mux, how many cycles it has shown, dead cycles left.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner = -1; used = 0; dead = 0; ptr = 0; exp_sel = 0;
        end else begin
            cyc++;
            if (owner >= 0) dq.push_back('{cyc, int'(din[owner])});
            if (owner >= 0) begin
                if (!req[owner] || used == BL) begin
                    nxt = -1;
                    ptr = (owner + 1) % N;
`ifdef MUX_SCHED_B2B_EN
                    for (int i = N - 1; i >= 1; i--)
                        if (req[(owner + i) % N]) nxt = (owner + i) % N;
`endif
                    owner = nxt;
                    used  = (nxt >= 0) ? 1 : 0;
                    dead  = (nxt >= 0) ? 0 : 1;
                end else begin
                    used++;
                end
            end else if (dead > 0) begin
                dead--;
            end else if (req != 0) begin
                for (int i = N - 1; i >= 0; i--)
                    if (req[(ptr + i) % N]) owner = (ptr + i) % N;
                used = 1;
            end
            if (owner >= 0) begin
                exp_sel = owner;
                gq.push_back('{cyc, owner});
            end
        end
    end

    // Monitor: compare DUT outputs against the queued expectations.
    always @(negedge clk) begin
        bit eg, ed;
        if (!rst_n) begin
            gq.delete();
            dq.delete();
            last_b = 0;
        end else begin
            eg = (gq.size() > 0) && (gq[0].cyc == cyc);
            check("gnt_active", int'(gnt != 0), int'(eg));
            if (eg) begin
                if (gnt != 0) check("gnt", int'(gnt), 1 << gq[0].val);
                void'(gq.pop_front());
            end
            check("sel", int'(sel), exp_sel);
            ed = (dq.size() > 0) && (dq[0].cyc == cyc);
            check("b_vld", int'(b_vld), int'(ed));
            if (ed) begin
                last_b = dq[0].val;
                void'(dq.pop_front());
            end
            check("b", int'(b), last_b);
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_gnt(input string name, input logic [4:0] mask);
        int n;
        for (n = 0; n < 40; n++) begin
            tick();
            if ((gnt & mask) != 0) break;
        end
        if (n == 40) timeout(name);
    endtask

    task automatic grant_and_drop(input int k);
        req = 5'(1) << k;
        wait_gnt("drop_wait", 5'(1) << k);
        req = '0;
        repeat (4) tick();
    endtask

    task automatic expect_next(input string name, input logic [4:0] r, input logic [4:0] e);
        req = r;
        wait_gnt(name, 5'b11111);
        check(name, int'(gnt), int'(e));
    endtask

    initial begin
        // Reset held with every requester asserting.
        req = 5'b11111;
        rst_n = 1'b0;
        repeat (3) tick();
        check("rst_gnt", int'(gnt), 0);
        check("rst_sel", int'(sel), 0);
        check("rst_b", int'(b), 0);
        check("rst_bvld", int'(b_vld), 0);
        rst_n = 1'b1;
        tick();
        check("first_gnt", int'(gnt), 1);

        // Full-load rotation.
        repeat (60) begin tick(); din = 5'($urandom); end
        req = '0;
        repeat (4) tick();

        // Early release of requester 2, next goes to 3.
        grant_and_drop(2);
        expect_next("after_early", 5'b01001, 5'b01000);
        req = '0;
        repeat (6) tick();

        // Wrap: ptr=4 with only requester 0 asking.
        grant_and_drop(3);
        expect_next("wrap0", 5'b00001, 5'b00001);
        req = '0;
        repeat (6) tick();
        grant_and_drop(3);
        expect_next("wrap4", 5'b10001, 5'b10000);
        wait_gnt("wrap_then0", 5'b00001);
        check("wrap_then0", int'(gnt), 1);
        req = '0;
        repeat (6) tick();

        // Data path: requester 3 with din[3] toggling 1,0,1.
        req = 5'b01000;
        wait_gnt("data_wait", 5'b01000);
        din = 5'b01000; tick();
        din = 5'b00000; tick();
        din = 5'b01000; tick();
        req = '0;
        din = '0;
        repeat (6) tick();

        // Mid-burst asynchronous reset during owner 2's second cycle.
        req = 5'b00100;
        wait_gnt("mid_wait", 5'b00100);
        tick();
        #1 rst_n = 1'b0;
        #1;
        check("mid_rst_gnt", int'(gnt), 0);
        check("mid_rst_sel", int'(sel), 0);
        check("mid_rst_b", int'(b), 0);
        check("mid_rst_bvld", int'(b_vld), 0);
        tick();
        req = 5'b11111;
        rst_n = 1'b1;
        tick();
        check("post_rst_gnt", int'(gnt), 1);

        // Randomized traffic.
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 3) == 0) req = req ^ (5'(1) << $urandom_range(0, 4));
            if ($urandom_range(0, 40) == 0) req = 5'($urandom);
            din = 5'($urandom);
            tick();
        end
        req = '0;
        repeat (8) tick();
        @(negedge clk);
        #1;
        check("sb_drain", gq.size() + dq.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mux_rr_sched.md
# mux_rr_sched

- Round-robin scheduler that shares the 5:1 one-bit select mux among five requesters.
- Owns the mux select: it grants one requester at a time for a bounded burst, drives `sel` and a one-hot grant, and registers the selected data bit into `b`.
- Sits directly in front of the mux datapath and replaces any free-running select source.

## Interface
- `N_REQ`, 5: requester count; fixed at 5, and `sel` is 3 bits.
- `BURST_LEN`, 4: maximum consecutive grant cycles per owner; legal range 1..15.
- `clk`  input  1  clock; all state updates on the rising edge.
- `rst_n`  input  1  reset; asynchronous and active-low.
- `req`  input  5  level request, one bit per requester.
- `din`  input  5  data bit per requester (the mux inputs i0..i4).
- `sel`  output  3  registered mux select, the current owner index 0..4.
- `gnt`  output  5  registered one-hot grant.
- `b`  output  1  registered selected data bit.
- `b_vld`  output  1  high when `b` holds data sampled under a grant.

## Operation
- State machine: IDLE, GRANT, GAP.
- IDLE:
  - If any `req` bit is set, pick the first set bit searching upward from `ptr` with wrap 4->0.
  - Load `sel`/`gnt` with the winner, clear `cnt`, and go to GRANT.
  - Otherwise stay in IDLE with `gnt`=0.
- GRANT:
  - `cnt` increments every cycle.
  - Leave GRANT when `req[sel]` is low, or when `cnt`==BURST_LEN-1. The first condition is checked first.
  - On leaving: `ptr` <= `sel`+1, wrapping 4->0. `gnt` <= 0. Go to GAP.
- GAP: one dead cycle with `gnt`=0, then go to IDLE. `sel` holds the last owner through GAP and IDLE.
- Data path:
  - `b` <= `din[sel]` every cycle that `gnt`!=0.
  - `b_vld` <= (`gnt`!=0).
  - `b` holds its value when `b_vld` falls.
- `sel` values 5..7 are never produced. `gnt` is always one-hot or zero.
- A request that arrives during GRANT or GAP waits. Requests are not latched; a request dropped before arbitration is lost.
- Fairness: with all five requesters asserting continuously, grants rotate 0,1,2,3,4,0… and each owner gets exactly BURST_LEN cycles.

## Timing
- Reset values: `sel`=0, `gnt`=0, `b`=0, `b_vld`=0, `ptr`=0, `cnt`=0, state IDLE.
- Reset is asynchronous. Asserting `rst_n` mid-burst clears all outputs immediately, with no clock needed, and the burst is abandoned.
- Request to grant: `req` high at edge t in IDLE gives `gnt`/`sel` valid after edge t.
- Grant to data: `b`/`b_vld` lag `gnt` by one cycle, so `b` carries `din` sampled at the edge while `gnt` is asserted.
- Burst length:
  - Maximum: `gnt` is high for exactly BURST_LEN cycles.
  - Minimum: 1 cycle, when `req` drops right after the grant.
- Handoff: last GRANT cycle, then GAP (1 cycle), then IDLE evaluation (1 cycle), then the new grant. Owner-to-owner gap is 2 cycles with `gnt`=0.
- Simultaneous requests: resolved only by `ptr` order. If the owner re-requests while others are waiting, it is served last in the rotation.
- `cnt` is 4 bits and never exceeds BURST_LEN-1.

## Configuration
- Macro `MUX_SCHED_B2B_EN`.
- When defined:
  - On leaving GRANT, if another requester (search from `sel`+1) is set, go straight to GRANT with the new winner, loading `sel`/`gnt` in the same edge.
  - No GAP or IDLE cycles; `b_vld` stays high across the handoff.
  - If no other requester is set, behaviour is as without the macro.
- When undefined: the GAP/IDLE sequence above; GAP is a live state.
- Reset values and fairness order are identical in both builds.

## Test plan
- Reset: hold `rst_n`=0 with `req`=5'b11111. Then: `gnt`=0, `sel`=0, `b`=0, `b_vld`=0. After release, first grant is `gnt`=5'b00001.
- Rotation, BURST_LEN=4, `req`=5'b11111 held:
  - Grants are 0,1,2,3,4,0, each 4 cycles long.
  - Gaps are 2 idle cycles, or 0 with `MUX_SCHED_B2B_EN`.
  - `sel` never exceeds 4.
- Early release: grant requester 2, drop `req[2]` after 1 cycle. Then: `gnt[2]` is high 1–2 cycles, `ptr`=3, and the next grant goes to 3 when `req`=5'b01001.
- Data path: grant requester 3 with `din[3]` toggling 1,0,1. Then: `b` follows 1,0,1 one cycle later, `b_vld`=1, and `b` holds the last value after the grant ends.
- Wrap: with `ptr`=4 and `req`=5'b00001, the grant goes to 0. With `req`=5'b10001 and `ptr`=4, the grant goes to 4 and then to 0.
- Mid-burst reset: assert `rst_n`=0 asynchronously during cycle 2 of a grant. Then: outputs clear before the next edge, and after release `ptr`=0.
